// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the ID-stage control-transfer resolver: FSM states,
// source priority and jump-target field widths.
package branch_resolve_unit_pkg;

  typedef enum logic {
    RESOLVE = 1'b0,
    STALL   = 1'b1
  } state_e;

  // Encoded in ascending priority; SRC_NONE means no control transfer decoded.
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_BNE  = 3'd1,
    SRC_BEQ  = 3'd2,
    SRC_JUMP = 3'd3,
    SRC_JREG = 3'd4
  } src_e;

  localparam int JSEG_W = 4;
  localparam int JIDX_W = 26;

  function automatic src_e pick_src(logic jreg, logic jump, logic beq, logic bne);
    if (jreg)      return SRC_JREG;
    else if (jump) return SRC_JUMP;
    else if (beq)  return SRC_BEQ;
    else if (bne)  return SRC_BNE;
    else           return SRC_NONE;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ID-stage decode/hazard inputs and redirect/stall/statistics outputs of the
// branch resolver. master = pipeline side, slave = resolver.
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int PCBITS  = 32,
  parameter int RBITS   = 5,
  parameter int CNTBITS = 32
);
  logic               i_valid;
  logic               i_ext_stall;
  logic               i_beq;
  logic               i_bne;
  logic               i_jump;
  logic               i_jreg;
  logic               i_zero;
  logic [PCBITS-1:0]  i_pc_plus4;
  logic [PCBITS-1:0]  i_imm;
  logic [JIDX_W-1:0]  i_jidx;
  logic [PCBITS-1:0]  i_rs_data;
  logic [RBITS-1:0]   i_rs_addr;
  logic [RBITS-1:0]   i_rt_addr;
  logic               i_ex_regwrite;
  logic               i_ex_memread;
  logic [RBITS-1:0]   i_ex_rd;
  logic               i_mem_memread;
  logic [RBITS-1:0]   i_mem_rd;
  logic               o_stall;
  logic               o_pc_src;
  logic [PCBITS-1:0]  o_target;
  logic               o_flush_ifid;
  logic [CNTBITS-1:0] o_branch_cnt;
  logic [CNTBITS-1:0] o_taken_cnt;

  modport master (
    output i_valid, i_ext_stall, i_beq, i_bne, i_jump, i_jreg, i_zero,
           i_pc_plus4, i_imm, i_jidx, i_rs_data, i_rs_addr, i_rt_addr,
           i_ex_regwrite, i_ex_memread, i_ex_rd, i_mem_memread, i_mem_rd,
    input  o_stall, o_pc_src, o_target, o_flush_ifid, o_branch_cnt, o_taken_cnt
  );

  modport slave (
    input  i_valid, i_ext_stall, i_beq, i_bne, i_jump, i_jreg, i_zero,
           i_pc_plus4, i_imm, i_jidx, i_rs_data, i_rs_addr, i_rt_addr,
           i_ex_regwrite, i_ex_memread, i_ex_rd, i_mem_memread, i_mem_rd,
    output o_stall, o_pc_src, o_target, o_flush_ifid, o_branch_cnt, o_taken_cnt
  );
endinterface

// File: rtl/branch_resolve_unit_hazard.sv
// Operand hazard depth for the control transfer in ID: 2 = EX load,
// 1 = EX ALU result or MEM load, 0 = operands ready.
module branch_hazard_detect
  import branch_resolve_unit_pkg::*;
#(
  parameter int RBITS = 5
) (
  input  src_e             src,
  input  logic [RBITS-1:0] rs_addr,
  input  logic [RBITS-1:0] rt_addr,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [RBITS-1:0] ex_rd,
  input  logic             mem_memread,
  input  logic [RBITS-1:0] mem_rd,
  output logic [1:0]       n
);
  logic uses_rs, uses_rt, ex_hit, mem_hit;

  assign uses_rs = (src == SRC_BEQ) || (src == SRC_BNE) || (src == SRC_JREG);
  assign uses_rt = (src == SRC_BEQ) || (src == SRC_BNE);

  // r0 is hardwired zero, so a write to it never blocks a reader.
  assign ex_hit  = (ex_rd != '0) &&
                   ((uses_rs && ex_rd == rs_addr) || (uses_rt && ex_rd == rt_addr));
  assign mem_hit = (mem_rd != '0) &&
                   ((uses_rs && mem_rd == rs_addr) || (uses_rt && mem_rd == rt_addr));

  always_comb begin
    n = 2'd0;
    if (ex_memread && ex_hit)
      n = 2'd2;
    else if ((ex_regwrite && !ex_memread && ex_hit) || (mem_memread && mem_hit))
      n = 2'd1;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/jump resolver: hazard stall FSM, zero-latency redirect
// and flush, and branch/taken statistics for the debug unit.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PCBITS  = 32,
  parameter int RBITS   = 5,
  parameter int CNTBITS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  branch_resolve_unit_if.slave bus
);
  state_e             state, state_nxt;
  src_e               src;
  logic [1:0]         n;
  logic               ctrl, is_br, taken, resolve, stall;
  logic [PCBITS-1:0]  target, br_target;
  logic [CNTBITS-1:0] branch_cnt, taken_cnt;

  assign src   = pick_src(bus.i_jreg, bus.i_jump, bus.i_beq, bus.i_bne);
  assign ctrl  = bus.i_valid && (src != SRC_NONE);
  assign is_br = (src == SRC_BEQ) || (src == SRC_BNE);
  assign taken = (src == SRC_JREG) || (src == SRC_JUMP) ||
                 (src == SRC_BEQ && bus.i_zero) || (src == SRC_BNE && !bus.i_zero);

  branch_hazard_detect #(.RBITS(RBITS)) u_hazard (
    .src         (src),
    .rs_addr     (bus.i_rs_addr),
    .rt_addr     (bus.i_rt_addr),
    .ex_regwrite (bus.i_ex_regwrite),
    .ex_memread  (bus.i_ex_memread),
    .ex_rd       (bus.i_ex_rd),
    .mem_memread (bus.i_mem_memread),
    .mem_rd      (bus.i_mem_rd),
    .n           (n)
  );

  assign br_target = bus.i_pc_plus4 + (bus.i_imm << 2);

  always_comb begin
    target = bus.i_pc_plus4;
    case (src)
      SRC_JREG: target = bus.i_rs_data;
      SRC_JUMP: target = {bus.i_pc_plus4[PCBITS-1 -: JSEG_W], bus.i_jidx, 2'b00};
      SRC_BEQ,
      SRC_BNE:  if (taken) target = br_target;
      default:  target = bus.i_pc_plus4;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= RESOLVE;
    else         state <= state_nxt;
  end

  // Stall is still reported under ext_stall, but nothing resolves and the FSM holds.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    resolve   = 1'b0;
    if (!bus.i_valid) begin
      state_nxt = RESOLVE;
    end else if (state == STALL) begin
      stall     = 1'b1;
      state_nxt = RESOLVE;
    end else if (ctrl) begin
      if (n != 2'd0) begin
        stall     = 1'b1;
        state_nxt = (n == 2'd2) ? STALL : RESOLVE;
      end else begin
        resolve = !bus.i_ext_stall;
      end
    end
    if (bus.i_ext_stall) state_nxt = state;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (resolve) begin
      if (is_br) branch_cnt <= branch_cnt + 1'b1;
      if (taken) taken_cnt  <= taken_cnt + 1'b1;
    end
  end

  assign bus.o_stall      = stall && !i_reset;
  assign bus.o_pc_src     = resolve && taken && !i_reset;
  assign bus.o_flush_ifid = resolve && taken && !i_reset;
  assign bus.o_target     = i_reset ? '0 : target;
  assign bus.o_branch_cnt = branch_cnt;
  assign bus.o_taken_cnt  = taken_cnt;
endmodule
